tcdm_multiport_memory: RTL and testbench

Multi-port, word-oriented TCDM slave memory used as instruction, stack and data store around the core and the accelerator. It serves MP independent request ports against one shared byte-addressed array. Grants are combinational, with optional pseudo-random stalls, and responses arrive one cycle after the grant. Per-port read and write counters are exposed for bandwidth reporting.

---
 rtl/tcdm_mem_pkg.sv | 24 ++
 rtl/tcdm_mem_lfsr.sv | 20 ++
 rtl/tcdm_multiport_memory.sv | 114 +++++++++++
 tb/tb_tcdm_multiport_memory.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_mem_pkg.sv
// Shared widths, LFSR constants and request bundle type for the TCDM multiport memory.
package tcdm_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_BASE = 32'hACE1_0000;

  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] add;
    logic              wen;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } tcdm_req_t;

  // Right-shifting Galois step: the bit shifted out decides whether the taps are applied.
  function automatic logic [31:0] lfsr_step(input logic [31:0] state);
    return {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/tcdm_mem_lfsr.sv
// Free-running 32-bit Galois LFSR; one per port drives stall decisions and randomized read data.
module tcdm_mem_lfsr
  import tcdm_mem_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED_BASE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] lfsr_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_o <= SEED;
    end else begin
      lfsr_o <= lfsr_step(lfsr_o);
    end
  end

endmodule

// File: rtl/tcdm_multiport_memory.sv
// Multi-port word-oriented TCDM slave memory: combinational grants with optional random
// stalls, one-cycle responses, read-before-write array semantics and per-port counters.
module tcdm_multiport_memory
  import tcdm_mem_pkg::*;
#(
  parameter int unsigned MP          = 1,
  parameter int unsigned MEMORY_SIZE = 196608,
  parameter logic [31:0] BASE_ADDR   = 32'h1c01_0000,
  parameter int unsigned PROB_STALL  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 stallable_i,
  input  logic                 randomize_i,
  input  logic [MP-1:0]        req_i,
  input  logic [MP*ADDR_W-1:0] add_i,
  input  logic [MP-1:0]        wen_i,
  input  logic [MP*BE_W-1:0]   be_i,
  input  logic [MP*DATA_W-1:0] data_i,
  output logic [MP-1:0]        gnt_o,
  output logic [MP*DATA_W-1:0] r_data_o,
  output logic [MP-1:0]        r_valid_o,
  output logic [MP*32-1:0]     cnt_rd_o,
  output logic [MP*32-1:0]     cnt_wr_o
);

  localparam int unsigned WORDS = MEMORY_SIZE / 4;
  localparam int unsigned OFF_W = $clog2(MEMORY_SIZE);
  localparam int unsigned IDX_W = OFF_W - 2;

  logic [7:0]        memory [MEMORY_SIZE];

  tcdm_req_t         port_req [MP];
  logic [31:0]       lfsr     [MP];
  logic [MP-1:0]     stall_hit;
  logic [MP-1:0]     stall;
  logic [ADDR_W-1:0] offset   [MP];
  logic [IDX_W-1:0]  word_idx [MP];
  logic [DATA_W-1:0] word_rd  [MP];
  logic [MP-1:0]     unused_off;

  for (genvar i = 0; i < MP; i++) begin : g_port
    assign port_req[i] = '{
      req:  req_i[i],
      add:  add_i[i*ADDR_W +: ADDR_W],
      wen:  wen_i[i],
      be:   be_i[i*BE_W +: BE_W],
      data: data_i[i*DATA_W +: DATA_W]
    };

    tcdm_mem_lfsr #(
      .SEED(LFSR_SEED_BASE + 32'(i))
    ) u_lfsr (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .lfsr_o (lfsr[i])
    );

    if (PROB_STALL == 0) begin : g_no_stall
      assign stall_hit[i] = 1'b0;
    end else begin : g_stall
      assign stall_hit[i] = (32'(lfsr[i][9:0]) % 32'd100) < PROB_STALL;
    end

    assign stall[i] = stallable_i & stall_hit[i];
    assign gnt_o[i] = port_req[i].req & enable_i & ~stall[i];

    // Addresses below the base wrap around; the low two address bits never select a byte.
    assign offset[i]     = port_req[i].add - BASE_ADDR;
    assign word_idx[i]   = IDX_W'(32'(offset[i][OFF_W-1:2]) % WORDS);
    assign unused_off[i] = ^{offset[i][1:0], offset[i][ADDR_W-1:OFF_W]};

    assign word_rd[i] = {memory[{word_idx[i], 2'd3}],
                         memory[{word_idx[i], 2'd2}],
                         memory[{word_idx[i], 2'd1}],
                         memory[{word_idx[i], 2'd0}]};
  end

  // Later ports overwrite earlier ones on the same byte because their assignment comes last.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (gnt_o[i] && !port_req[i].wen) begin
        for (int b = 0; b < BE_W; b++) begin
          if (port_req[i].be[b]) begin
            memory[{word_idx[i], 2'(b)}] <= port_req[i].data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_o <= '0;
      r_data_o  <= '0;
      cnt_rd_o  <= '0;
      cnt_wr_o  <= '0;
    end else begin
      r_valid_o <= gnt_o;
      for (int i = 0; i < MP; i++) begin
        if (gnt_o[i]) begin
          if (port_req[i].wen) begin
            r_data_o[i*DATA_W +: DATA_W] <= randomize_i ? lfsr[i] : word_rd[i];
            cnt_rd_o[i*32 +: 32]         <= cnt_rd_o[i*32 +: 32] + 32'd1;
          end else begin
            cnt_wr_o[i*32 +: 32]         <= cnt_wr_o[i*32 +: 32] + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tcdm_multiport_memory.sv
// Directed scoreboard bench for tcdm_multiport_memory: a 2-port no-stall instance plus
// always-stall and half-stall single-port instances sharing clock, reset and control.
module tb_tcdm_multiport_memory;

  localparam logic [31:0] BASE = 32'h1c01_0000;
  localparam int unsigned MS_A = 4096;

  typedef struct {
    int          port;
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst, enable, stallable, randomize;
  logic [1:0]  req_a, wen_a, gnt_a, rvalid_a;
  logic [63:0] add_a, data_a, rdata_a, cnt_rd_a, cnt_wr_a;
  logic [7:0]  be_a;
  logic        req_s, wen_s;
  logic [31:0] add_s, data_s;
  logic [3:0]  be_s;
  logic        gnt_b, rvalid_b, gnt_c, rvalid_c;
  logic [31:0] rdata_b, cnt_rd_b, cnt_wr_b, rdata_c, cnt_rd_c, cnt_wr_c;

  int          compared   = 0;
  int          mismatched = 0;
  exp_t        sb[$];
  logic [31:0] mem_model [int];
  logic [31:0] last_rdata [2];
  int          exp_rd [2];
  int          exp_wr [2];
  logic [31:0] m_lfsr [2];

  tcdm_multiport_memory #(
    .MP(2), .MEMORY_SIZE(MS_A), .BASE_ADDR(BASE), .PROB_STALL(0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .stallable_i(stallable),
    .randomize_i(randomize), .req_i(req_a), .add_i(add_a), .wen_i(wen_a),
    .be_i(be_a), .data_i(data_a), .gnt_o(gnt_a), .r_data_o(rdata_a),
    .r_valid_o(rvalid_a), .cnt_rd_o(cnt_rd_a), .cnt_wr_o(cnt_wr_a)
  );

  tcdm_multiport_memory #(
    .MP(1), .BASE_ADDR(BASE), .PROB_STALL(100)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .stallable_i(stallable),
    .randomize_i(randomize), .req_i(req_s), .add_i(add_s), .wen_i(wen_s),
    .be_i(be_s), .data_i(data_s), .gnt_o(gnt_b), .r_data_o(rdata_b),
    .r_valid_o(rvalid_b), .cnt_rd_o(cnt_rd_b), .cnt_wr_o(cnt_wr_b)
  );

  tcdm_multiport_memory #(
    .MP(1), .MEMORY_SIZE(1024), .BASE_ADDR(BASE), .PROB_STALL(50)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .stallable_i(stallable),
    .randomize_i(randomize), .req_i(req_s), .add_i(add_s), .wen_i(wen_s),
    .be_i(be_s), .data_i(data_s), .gnt_o(gnt_c), .r_data_o(rdata_c),
    .r_valid_o(rvalid_c), .cnt_rd_o(cnt_rd_c), .cnt_wr_o(cnt_wr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSRs for ports 0 and 1 (port-0 seed is shared by all three instances).
  always @(posedge clk or posedge rst) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) m_lfsr[p] <= 32'hACE1_0000 + 32'(p);
      else if (m_lfsr[p][0]) m_lfsr[p] <= (m_lfsr[p] >> 1) ^ 32'h8020_0003;
      else m_lfsr[p] <= m_lfsr[p] >> 1;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int widx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'((off % MS_A) / 4);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic wen, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data);
    req_a[p]            = 1'b1;
    wen_a[p]            = wen;
    add_a[p*32 +: 32]   = addr;
    be_a[p*4 +: 4]      = be;
    data_a[p*32 +: 32]  = data;
  endtask

  task automatic check_responses();
    exp_t       e;
    logic [1:0] due;
    due = '0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      due[e.port] = 1'b1;
      if (e.is_read) begin
        check_output($sformatf("r_data%0d", e.port), rdata_a[e.port*32 +: 32], e.data);
        last_rdata[e.port] = e.data;
      end else begin
        check_output($sformatf("r_data_hold%0d", e.port), rdata_a[e.port*32 +: 32], last_rdata[e.port]);
      end
    end
    for (int p = 0; p < 2; p++) begin
      check_output($sformatf("r_valid%0d", p), 32'(rvalid_a[p]), 32'(due[p]));
      check_output($sformatf("cnt_rd%0d", p), cnt_rd_a[p*32 +: 32], 32'(exp_rd[p]));
      check_output($sformatf("cnt_wr%0d", p), cnt_wr_a[p*32 +: 32], 32'(exp_wr[p]));
    end
  endtask

  // Called right after the active edge with port-A requests already placed.
  task automatic apply_stimulus();
    exp_t        e;
    logic [31:0] w;
    int          k;
    #1;
    for (int p = 0; p < 2; p++) begin
      check_output($sformatf("gnt_a%0d", p), 32'(gnt_a[p]), 32'(req_a[p] & enable));
    end
    for (int p = 0; p < 2; p++) begin
      if (req_a[p] && enable && wen_a[p]) begin
        k = widx(add_a[p*32 +: 32]);
        e.port    = p;
        e.is_read = 1'b1;
        e.data    = randomize ? m_lfsr[p] : (mem_model.exists(k) ? mem_model[k] : 32'h0);
        sb.push_back(e);
        exp_rd[p]++;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (req_a[p] && enable && !wen_a[p]) begin
        k = widx(add_a[p*32 +: 32]);
        w = mem_model.exists(k) ? mem_model[k] : 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (be_a[p*4 + b]) w[8*b +: 8] = data_a[p*32 + 8*b +: 8];
        end
        mem_model[k] = w;
        e.port    = p;
        e.is_read = 1'b0;
        e.data    = 32'h0;
        sb.push_back(e);
        exp_wr[p]++;
      end
    end
    @(posedge clk);
    #1;
    req_a = '0;
    check_responses();
  endtask

  initial begin
    logic [31:0] stall_val, lf_c, lf_last;
    logic        exp_c;
    int          n_c;

    rst = 1'b1; enable = 1'b1; stallable = 1'b1; randomize = 1'b0;
    req_a = '0; wen_a = '0; add_a = '0; be_a = '0; data_a = '0;
    req_s = 1'b0; wen_s = 1'b1; add_s = BASE; be_s = '0; data_s = '0;
    exp_rd = '{0, 0}; exp_wr = '{0, 0}; last_rdata = '{32'h0, 32'h0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset released");
    for (int p = 0; p < 2; p++) begin
      check_output($sformatf("rst_r_data%0d", p), rdata_a[p*32 +: 32], 32'h0);
    end
    check_responses();

    // Preload, then a plain read
    set_port(0, 1'b0, BASE, 4'hF, 32'h1122_3344);          apply_stimulus();
    set_port(0, 1'b0, BASE + 4, 4'hF, 32'h0);              apply_stimulus();
    set_port(0, 1'b1, BASE, 4'h0, 32'h0);                  apply_stimulus();

    // Partial byte-enable write over zero
    set_port(0, 1'b0, BASE + 4, 4'b0101, 32'hAABB_CCDD);   apply_stimulus();
    set_port(0, 1'b1, BASE + 4, 4'h0, 32'h0);              apply_stimulus();

    // Read-before-write on the same word in one cycle
    set_port(1, 1'b0, BASE + 8, 4'hF, 32'h1234_5678);      apply_stimulus();
    set_port(0, 1'b1, BASE + 8, 4'h0, 32'h0);
    set_port(1, 1'b0, BASE + 8, 4'hF, 32'hFFFF_FFFF);      apply_stimulus();
    set_port(0, 1'b1, BASE + 8, 4'h0, 32'h0);              apply_stimulus();

    // Same-byte write collision: higher port wins
    set_port(0, 1'b0, BASE + 12, 4'hF, 32'h1);
    set_port(1, 1'b0, BASE + 12, 4'hF, 32'h2);             apply_stimulus();
    set_port(0, 1'b1, BASE + 12, 4'h0, 32'h0);             apply_stimulus();

    // Below-base and above-size wrapping, low address bits ignored
    set_port(1, 1'b0, BASE - 4, 4'hF, 32'hCAFE_F00D);      apply_stimulus();
    set_port(0, 1'b1, BASE + MS_A - 2, 4'h0, 32'h0);
    set_port(1, 1'b1, BASE + MS_A, 4'h0, 32'h0);           apply_stimulus();

    // Both ports reading distinct words together
    set_port(0, 1'b1, BASE + 4, 4'h0, 32'h0);
    set_port(1, 1'b1, BASE + 12, 4'h0, 32'h0);             apply_stimulus();

    // Disabled: no grant, no response, counters hold
    enable = 1'b0;
    set_port(0, 1'b1, BASE, 4'h0, 32'h0);
    set_port(1, 1'b0, BASE, 4'hF, 32'h0);                  apply_stimulus();
    enable = 1'b1;

    // Reset during a granted read drops the response
    set_port(0, 1'b1, BASE, 4'h0, 32'h0);
    #1;
    check_output("gnt_before_rst", 32'(gnt_a[0]), 32'h1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_a = '0;
    sb.delete();
    exp_rd = '{0, 0}; exp_wr = '{0, 0}; last_rdata = '{32'h0, 32'h0};
    for (int p = 0; p < 2; p++) begin
      check_output($sformatf("mid_rst_r_data%0d", p), rdata_a[p*32 +: 32], 32'h0);
    end
    check_responses();

    // Array survives reset; randomized reads return the port LFSR
    set_port(0, 1'b1, BASE + 4, 4'h0, 32'h0);              apply_stimulus();
    randomize = 1'b1;
    set_port(0, 1'b1, BASE, 4'h0, 32'h0);
    set_port(1, 1'b1, BASE, 4'h0, 32'h0);                  apply_stimulus();

    // Stall behaviour on the single-port instances (randomized data still on)
    req_s = 1'b1;
    n_c = 0;
    lf_last = 32'h0;
    for (int k = 0; k < 20; k++) begin
      #1;
      check_output("gnt_b_stalled", 32'(gnt_b), 32'h0);
      stall_val = 32'(m_lfsr[0][9:0]) % 32'd100;
      exp_c = (stall_val >= 32'd50);
      lf_c = m_lfsr[0];
      check_output("gnt_c", 32'(gnt_c), 32'(exp_c));
      @(posedge clk);
      #1;
      check_output("r_valid_b_stalled", 32'(rvalid_b), 32'h0);
      check_output("r_valid_c", 32'(rvalid_c), 32'(exp_c));
      if (exp_c) begin
        n_c++;
        lf_last = lf_c;
      end
      check_output("r_data_c", rdata_c, lf_last);
    end
    req_s = 1'b0;
    check_output("cnt_rd_b_stalled", cnt_rd_b, 32'h0);
    check_output("cnt_wr_b", cnt_wr_b, 32'h0);
    check_output("r_data_b_stalled", rdata_b, 32'h0);
    check_output("cnt_rd_c", cnt_rd_c, 32'(n_c));
    check_output("cnt_wr_c", cnt_wr_c, 32'h0);

    stallable = 1'b0;
    req_s = 1'b1;
    #1;
    check_output("gnt_b_unstalled", 32'(gnt_b), 32'h1);
    check_output("gnt_c_unstalled", 32'(gnt_c), 32'h1);
    lf_c = m_lfsr[0];
    @(posedge clk);
    #1;
    req_s = 1'b0;
    check_output("r_valid_b", 32'(rvalid_b), 32'h1);
    check_output("r_data_b", rdata_b, lf_c);
    check_output("cnt_rd_b", cnt_rd_b, 32'h1);
    check_output("r_valid_c_last", 32'(rvalid_c), 32'h1);
    check_output("cnt_rd_c_last", cnt_rd_c, 32'(n_c + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
